// File: rtl/pipe_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// pipe_pkg : shared state encoding for the valid/ready pipeline stage
// Rev 1.0
//------------------------------------------------------------------------------
package pipe_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// sat_counter : saturating up-counter with synchronous clear (clear wins)
// Rev 1.0
//------------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] c_max = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
//------------------------------------------------------------------------------
// pipe_stage_skid : valid/ready stage register with optional 2-entry skid buffer
// Rev 1.0
//------------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SKID_EN     = 1,
  parameter int BUBBLE_ZERO = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic c_skid   = (SKID_EN != 0);
  localparam logic c_bubble = (BUBBLE_ZERO != 0);

  pipe_state_t       r_state;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;

  logic w_acc;
  logic w_fire;

  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main;
  // Skid variant only ever deasserts ready from a register; the plain variant looks through to out_ready.
  assign in_ready  = c_skid ? r_in_ready : (!out_valid || out_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_fire    = out_valid && out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (flush) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      if (c_bubble) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_state    <= ST_FULL;
            r_main     <= in_data;
            r_in_ready <= 1'b1;
          end
        end
        ST_FULL: begin
          if (w_acc && w_fire) begin
            r_main <= in_data;
          end else if (w_acc && c_skid) begin
            // Downstream stalled: park the newer beat behind the main entry.
            r_state    <= ST_SKID;
            r_skid     <= in_data;
            r_in_ready <= 1'b0;
          end else if (w_fire) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            if (c_bubble) begin
              r_main <= '0;
              r_skid <= '0;
            end
          end
        end
        ST_SKID: begin
          if (w_fire) begin
            r_state    <= ST_FULL;
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (out_valid && !out_ready),
    .clr    (perf_clr),
    .cnt    (stall_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_pipe_stage_skid : queue-model scoreboard bench for skid and non-skid stages
// Rev 1.0
//------------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = 15;

  typedef logic [DW-1:0] q_t[$];

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_ready;
  logic          perf_clr;

  logic [1:0]    out_valid_v;
  logic [1:0]    in_ready_v;
  logic [DW-1:0] out_data_v [2];
  logic [CW-1:0] stall_v    [2];

  // index 0: skid buffer stage, index 1: single-register stage
  q_t m_q  [2];
  q_t sb_q [2];
  int exp_cnt [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1), .BUBBLE_ZERO(1), .CNT_W(CW)) u_dut_skid (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_v[0]), .in_data(in_data),
    .flush(flush), .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(out_data_v[0]),
    .perf_clr(perf_clr), .stall_cnt(stall_v[0])
  );

  pipe_stage_skid #(.DATA_W(DW), .SKID_EN(0), .BUBBLE_ZERO(1), .CNT_W(CW)) u_dut_flat (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_v[1]), .in_data(in_data),
    .flush(flush), .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(out_data_v[1]),
    .perf_clr(perf_clr), .stall_cnt(stall_v[1])
  );

  task automatic chk(input string nm, input int d, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of depth 2 (skid) or 1 (flat, with pass-through ready).
  task automatic model_step(input int d);
    int occ;
    logic exp_ir, acc, fire;
    if (!resetn) begin
      m_q[d].delete();
      sb_q[d].delete();
      exp_cnt[d] = 0;
      chk("rst_out_valid", d, DW'(out_valid_v[d]), '0);
      chk("rst_out_data", d, out_data_v[d], '0);
      chk("rst_in_ready", d, DW'(in_ready_v[d]), 1);
      chk("rst_stall_cnt", d, DW'(stall_v[d]), '0);
      return;
    end
    occ    = m_q[d].size();
    exp_ir = (d == 0) ? (occ < 2) : (occ == 0 || out_ready);
    chk("out_valid", d, DW'(out_valid_v[d]), DW'(occ > 0));
    chk("in_ready", d, DW'(in_ready_v[d]), DW'(exp_ir));
    chk("stall_cnt", d, DW'(stall_v[d]), DW'(exp_cnt[d]));
    if (occ == 0) chk("bubble_data", d, out_data_v[d], '0);
    else          chk("held_data", d, out_data_v[d], m_q[d][0]);
    acc  = in_valid && exp_ir;
    fire = (occ > 0) && out_ready;
    if (fire) sb_q[d].push_back(m_q[d].pop_front());
    if (flush)    m_q[d].delete();
    else if (acc) m_q[d].push_back(in_data);
    if (perf_clr) exp_cnt[d] = 0;
    else if (occ > 0 && !out_ready && exp_cnt[d] < CMAX) exp_cnt[d] = exp_cnt[d] + 1;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // Monitor: every delivered beat must match the next expected payload.
  always @(negedge clk) begin
    #1;
    for (int m = 0; m < 2; m++) begin
      if (resetn && out_valid_v[m] && out_ready) begin
        if (sb_q[m].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL mon_unexpected dut%0d @%0t: got beat %h expected none", m, $time, out_data_v[m]);
        end else begin
          chk("mon_data", m, out_data_v[m], sb_q[m].pop_front());
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] dat, input logic ordy, input logic fl, input logic clr);
    in_valid  = v;
    in_data   = dat;
    out_ready = ordy;
    flush     = fl;
    perf_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD;
    out_ready = 1'b0;
    flush     = 1'b0;
    perf_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", d, DW'(out_valid_v[d]), '0);
      chk("reset_data", d, out_data_v[d], '0);
    end
    resetn = 1'b1;

    // streaming
    for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // skid fill and ordered drain
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    chk("skid_in_ready", 0, DW'(in_ready_v[0]), '0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // flush with a concurrent incoming beat
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk("flush_valid", d, DW'(out_valid_v[d]), '0);
      chk("flush_data", d, out_data_v[d], '0);
    end
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // stall counter saturation and clear
    drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    repeat (20) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) chk("stall_sat", d, DW'(stall_v[d]), 32'd15);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++) chk("stall_clr", d, DW'(stall_v[d]), '0);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // flat stage: replace with no bubble
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    in_valid  = 1'b1;
    in_data   = 32'h22;
    out_ready = 1'b1;
    #1;
    chk("flat_comb_ready", 1, DW'(in_ready_v[1]), 1);
    @(posedge clk);
    #1;
    chk("flat_replace_data", 1, out_data_v[1], 32'h22);
    chk("flat_replace_valid", 1, DW'(out_valid_v[1]), 1);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // randomized traffic with occasional flush, clear and async reset
    for (int n = 0; n < 2000; n++) begin
      logic v, r, f, c;
      v = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 99) < 65);
      f = ($urandom_range(0, 29) == 0);
      c = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 399) == 0) begin
        resetn = 1'b0;
        drive(v, $urandom, r, f, c);
        resetn = 1'b1;
      end else begin
        drive(v, $urandom, r, f, c);
      end
    end

    repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("sb_drained", d, DW'(sb_q[d].size()), '0);
      chk("model_drained", d, DW'(m_q[d].size()), '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
